// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with direct-load and autonomous scan modes.
// Latency 1 cycle from load/en/mode to bus/index/err/wrap; no backpressure (free-running outputs).
module onehot_decoder_seq #(
  parameter int SEL_W   = 3,
  parameter int N_OUT   = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               mode,
  input  logic               load,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_OUT-1:0]   bus,
  output logic [SEL_W-1:0]   index,
  output logic               err,
  output logic               wrap
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIRECT = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  // N_OUT can equal 2**SEL_W, so range checks use one extra bit
  localparam logic [SEL_W:0]   NOUT_W = (SEL_W+1)'(N_OUT);
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(N_OUT - 1);
  localparam logic [N_OUT-1:0] ONE    = {{(N_OUT-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_m1;

  function automatic logic [N_OUT-1:0] decode(input logic [SEL_W-1:0] i);
    decode = ({1'b0, i} < NOUT_W) ? (ONE << i) : '0;
  endfunction

  always_comb begin
    state_nxt = IDLE;
    if (en) state_nxt = mode ? SCAN : DIRECT;
  end

  // dwell of 0 behaves as 1; compare with >= so a shrunk dwell steps immediately
  assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus   <= '0;
      index <= '0;
      err   <= 1'b0;
      wrap  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      wrap  <= 1'b0;
      case (state_nxt)
        DIRECT: begin
          if (load) begin
            index <= sel;
            bus   <= decode(sel);
            err   <= ({1'b0, sel} >= NOUT_W);
          end else begin
            bus <= decode(index);
          end
        end
        SCAN: begin
          if (state != SCAN) begin
            cnt <= '0;
            err <= 1'b0;
            if ({1'b0, index} < NOUT_W) begin
              bus <= decode(index);
            end else begin
              index <= '0;
              bus   <= ONE;
            end
          end else if (cnt >= dwell_m1) begin
            cnt <= '0;
            if (index >= LAST) begin
              index <= '0;
              bus   <= ONE;
              wrap  <= 1'b1;
            end else begin
              index <= index + SEL_W'(1);
              bus   <= ONE << (index + SEL_W'(1));
            end
          end else begin
            cnt <= cnt + DWELL_W'(1);
          end
        end
        default: bus <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: two instances (N_OUT=8 and N_OUT=6) share inputs and are
// compared each cycle against an elapsed-time reference model, plus directed expectations.
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       reset, en, mode, load;
  logic [2:0] sel;
  logic [7:0] dwell;
  logic [7:0] bus8;
  logic [5:0] bus6;
  logic [2:0] index8, index6;
  logic       err8, err6, wrap8, wrap6;

  int tests = 0;
  int fails = 0;
  bit running = 0;

  // reference model state: [0] for N_OUT=8, [1] for N_OUT=6
  int m_bus[2], m_idx[2], m_err[2], m_wrap[2], m_el[2], m_scan[2];

  onehot_decoder_seq #(.SEL_W(3), .N_OUT(8), .DWELL_W(8)) d8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .sel(sel), .dwell(dwell),
    .bus(bus8), .index(index8), .err(err8), .wrap(wrap8));

  onehot_decoder_seq #(.SEL_W(3), .N_OUT(6), .DWELL_W(8)) d6 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .sel(sel), .dwell(dwell),
    .bus(bus6), .index(index6), .err(err6), .wrap(wrap6));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (running) begin
      chk("onehot8", 32'($onehot0(bus8)), 32'd1);
      chk("onehot6", 32'($onehot0(bus6)), 32'd1);
    end
  end

  // Model tracks how many cycles the current position has been shown.
  task automatic model(input int k, input int n);
    int d;
    if (reset) begin
      m_bus[k] = 0; m_idx[k] = 0; m_err[k] = 0; m_wrap[k] = 0; m_el[k] = 0; m_scan[k] = 0;
    end else if (!en) begin
      m_bus[k] = 0; m_wrap[k] = 0; m_scan[k] = 0;
    end else if (!mode) begin
      m_wrap[k] = 0; m_scan[k] = 0;
      if (load) begin
        m_idx[k] = int'(sel);
        m_err[k] = (int'(sel) >= n) ? 1 : 0;
      end
      m_bus[k] = (m_idx[k] < n) ? (1 << m_idx[k]) : 0;
    end else begin
      m_wrap[k] = 0;
      d = (dwell == 0) ? 1 : int'(dwell);
      if (m_scan[k] == 0) begin
        m_el[k] = 1; m_err[k] = 0;
        if (m_idx[k] >= n) m_idx[k] = 0;
      end else if (m_el[k] >= d) begin
        m_idx[k] = (m_idx[k] + 1) % n;
        m_wrap[k] = (m_idx[k] == 0) ? 1 : 0;
        m_el[k] = 1;
      end else begin
        m_el[k]++;
      end
      m_bus[k] = 1 << m_idx[k];
      m_scan[k] = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model(0, 8);
    model(1, 6);
    #1;
    chk("bus8", 32'(bus8), m_bus[0]);
    chk("idx8", 32'(index8), m_idx[0]);
    chk("err8", 32'(err8), m_err[0]);
    chk("wrap8", 32'(wrap8), m_wrap[0]);
    chk("bus6", 32'(bus6), m_bus[1]);
    chk("idx6", 32'(index6), m_idx[1]);
    chk("err6", 32'(err6), m_err[1]);
    chk("wrap6", 32'(wrap6), m_wrap[1]);
    running = 1;
  endtask

  initial begin
    logic [5:0] exp_bus[7];
    logic       exp_wrap[7];

    reset = 1; en = 1; mode = 1; load = 0; sel = 0; dwell = 3;
    tick();
    chk("reset_bus8", 32'(bus8), 0);
    chk("reset_idx6", 32'(index6), 0);
    reset = 0; en = 0;
    tick();
    chk("idle_bus8", 32'(bus8), 0);

    // direct sweep
    en = 1; mode = 0; load = 1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick();
      chk("sweep_bus8", 32'(bus8), 32'(1) << s);
      chk("sweep_err8", 32'(err8), 0);
    end

    // out-of-range on the six-output instance
    sel = 3'd6;
    tick();
    chk("oor_bus6", 32'(bus6), 0);
    chk("oor_err6", 32'(err6), 1);
    chk("oor_idx6", 32'(index6), 6);
    sel = 3'd2;
    tick();
    chk("inr_bus6", 32'(bus6), 32'h04);
    chk("inr_err6", 32'(err6), 0);

    // scan wrap with dwell=3 from index 4
    sel = 3'd4;
    tick();
    load = 0; mode = 1; dwell = 3;
    exp_bus  = '{6'h10, 6'h10, 6'h10, 6'h20, 6'h20, 6'h20, 6'h01};
    exp_wrap = '{0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("scan3_bus6", 32'(bus6), 32'(exp_bus[i]));
      chk("scan3_wrap6", 32'(wrap6), 32'(exp_wrap[i]));
    end

    // scan with dwell=0: one step per cycle
    mode = 0; load = 1; sel = 3'd4;
    tick();
    load = 0; mode = 1; dwell = 0;
    exp_bus  = '{6'h10, 6'h20, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10};
    exp_wrap = '{0, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("scan0_bus6", 32'(bus6), 32'(exp_bus[i]));
      chk("scan0_wrap6", 32'(wrap6), 32'(exp_wrap[i]));
    end

    // index is 3: disable, re-enable direct, then scan with an ignored load
    en = 0;
    tick();
    chk("dis_bus6", 32'(bus6), 0);
    en = 1; mode = 0;
    tick();
    chk("reen_bus6", 32'(bus6), 32'h08);
    mode = 1; load = 1; sel = 3'd1; dwell = 4;
    tick();
    chk("scanld_bus6", 32'(bus6), 32'h08);
    chk("scanld_idx6", 32'(index6), 3);
    load = 0;

    // reset mid-dwell
    tick();
    tick();
    reset = 1;
    tick();
    chk("mreset_bus6", 32'(bus6), 0);
    chk("mreset_idx6", 32'(index6), 0);
    chk("mreset_wrap6", 32'(wrap6), 0);
    reset = 0;

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      load  = $urandom_range(0, 1) == 1;
      sel   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) dwell = 8'($urandom_range(0, 4));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
